// File: rtl/memory_data.sv
// Word-addressed data memory: synchronous write, combinational read, async clear.
// Only the low DEPTH words exist; addresses at or above DEPTH read 0 and never write.
module memory_data #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 21,
  parameter int DEPTH      = 1024
) (
  input  logic [DATA_WIDTH-1:0] Mdst,
  output logic [DATA_WIDTH-1:0] Msrc1,
  input  logic [ADDR_WIDTH-1:0] Mdst_addr,
  input  logic [ADDR_WIDTH-1:0] Msrc1_addr,
  input  logic                  clk,
  input  logic                  Mwrite,
  input  logic                  reset
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Register array rather than block RAM: every word must clear asynchronously.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic             wr_in_range;
  logic             rd_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_in_range = Mdst_addr  < ADDR_WIDTH'(DEPTH);
  assign rd_in_range = Msrc1_addr < ADDR_WIDTH'(DEPTH);
  assign wr_idx      = Mdst_addr[IDX_W-1:0];
  assign rd_idx      = Msrc1_addr[IDX_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic                  we;
      logic [DATA_WIDTH-1:0] word_d;

      assign we     = Mwrite && wr_in_range && (wr_idx == IDX_W'(gi));
      assign word_d = we ? Mdst : mem_q[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= word_d;
        end
      end
    end
  endgenerate

  // Out-of-range reads return 0 instead of aliasing onto low words.
  always_comb begin
    Msrc1 = '0;
    if (rd_in_range) begin
      Msrc1 = mem_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_memory_data.sv
// Self-checking bench for memory_data: directed test plan, then randomized traffic
// compared every cycle against an array-based reference model.
module tb_memory_data;

  localparam int DW    = 16;
  localparam int AW    = 21;
  localparam int DEPTH = 1024;

  logic [DW-1:0] Mdst;
  logic [DW-1:0] Msrc1;
  logic [AW-1:0] Mdst_addr;
  logic [AW-1:0] Msrc1_addr;
  logic          clk;
  logic          Mwrite;
  logic          reset;

  memory_data #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .Mdst       (Mdst),
    .Msrc1      (Msrc1),
    .Mdst_addr  (Mdst_addr),
    .Msrc1_addr (Msrc1_addr),
    .clk        (clk),
    .Mwrite     (Mwrite),
    .reset      (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_valid = 1'b0;

  logic [DW-1:0] model [DEPTH];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: Msrc1_addr=%0h got %0d expected %0d at %0t", name, Msrc1_addr, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (a < AW'(DEPTH)) return model[a[9:0]];
    return '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  always @(posedge reset) model_clear();

  always @(posedge clk) begin
    if (!reset && Mwrite && (Mdst_addr < AW'(DEPTH))) model[Mdst_addr[9:0]] = Mdst;
  end

  always @(negedge clk) begin
    if (model_valid) check("cycle_read", Msrc1, model_rd(Msrc1_addr));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    Msrc1_addr = a;
    #1;
    check(name, Msrc1, exp);
    check({name, "_model"}, model_rd(a), exp);
  endtask

  initial begin
    Mdst = '0; Mdst_addr = '0; Msrc1_addr = '0; Mwrite = 1'b0; reset = 1'b0;
    model_clear();
    #1 reset = 1'b1;
    tick(); tick();
    model_valid = 1'b1;
    reset = 1'b0;
    tick();

    // 1: reset contents
    rd(21'd0, 16'd0, "reset_addr0");
    rd(21'd1, 16'd0, "reset_addr1");
    rd(21'd1023, 16'd0, "reset_addr_top");

    // 2: back-to-back writes, combinational readback
    Mwrite = 1'b1; Mdst_addr = 21'd1; Mdst = 16'd47;
    tick();
    Mdst_addr = 21'd2; Mdst = 16'd74;
    tick();
    Mwrite = 1'b0;
    rd(21'd1, 16'd47, "wr_addr1");
    rd(21'd2, 16'd74, "wr_addr2");

    // 3: disabled write
    Mdst_addr = 21'd5; Mdst = 16'd99;
    tick(); tick(); tick();
    rd(21'd5, 16'd0, "no_write_en");

    // 4: read-during-write same address
    Msrc1_addr = 21'd3; Mdst_addr = 21'd3; Mdst = 16'd123; Mwrite = 1'b1;
    #1 check("rdw_before_edge", Msrc1, 16'd0);
    @(posedge clk); #1;
    check("rdw_after_edge", Msrc1, 16'd123);
    Mdst = 16'd200;
    @(posedge clk); #1;
    check("rdw_overwrite", Msrc1, 16'd200);
    Mwrite = 1'b0;
    tick();

    // 5: out-of-range writes ignored
    Mwrite = 1'b1; Mdst = 16'd55; Mdst_addr = 21'd1024;
    tick();
    Mdst_addr = 21'h1FFFFF;
    tick();
    Mwrite = 1'b0;
    rd(21'd1024, 16'd0, "oor_read_depth");
    rd(21'h1FFFFF, 16'd0, "oor_read_max");
    rd(21'd0, 16'd0, "oor_no_alias0");
    rd(21'd1023, 16'd0, "oor_no_alias_top");
    rd(21'd2, 16'd74, "oor_addr2_kept");

    // 6: asynchronous reset mid-cycle
    Mwrite = 1'b1; Mdst_addr = 21'd1; Mdst = 16'd47;
    tick();
    Mwrite = 1'b0;
    rd(21'd1, 16'd47, "pre_reset");
    reset = 1'b1;
    #1 check("async_reset_clear", Msrc1, 16'd0);
    Mwrite = 1'b1; Mdst = 16'd77;
    @(posedge clk); #1;
    check("write_during_reset", Msrc1, 16'd0);
    reset = 1'b0; Mdst = 16'd9;
    @(posedge clk); #1;
    check("write_after_reset", Msrc1, 16'd9);
    Mwrite = 1'b0;
    tick();

    // Randomized traffic; compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      Mwrite = ($urandom_range(0, 3) != 0);
      Mdst   = DW'($urandom);
      case ($urandom_range(0, 9))
        0:       Mdst_addr = AW'($urandom_range(DEPTH, 21'h1FFFFF));
        1:       Mdst_addr = AW'($urandom_range(0, DEPTH - 1));
        default: Mdst_addr = AW'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 9))
        0:       Msrc1_addr = AW'($urandom_range(DEPTH, 21'h1FFFFF));
        1:       Msrc1_addr = AW'($urandom_range(0, DEPTH - 1));
        default: Msrc1_addr = AW'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      else reset = 1'b0;
      tick();
    end
    reset = 1'b0; Mwrite = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
